// File: rtl/pe_array_in_sel_ctrl_if.sv
// Handshake bundle between pe_array_in_sel_ctrl and the layer controller / buffer banks.
// The master modport is the sequencer side; the slave modport is the environment side.
interface pe_array_in_sel_ctrl_if;
  logic       start;
  logic       done;
  logic       busy;
  logic       w_load_req;
  logic       w_load_ack;
  logic       act_valid;
  logic       pe_ready;
  logic       act_rd_en;
  logic [1:0] compressed_act_in_sel;
  logic       last_row_shadow_afifo_in_sel;
  logic       wreg_in_sel;

  modport master (
    input  start, w_load_ack, act_valid, pe_ready,
    output done, busy, w_load_req, act_rd_en,
           compressed_act_in_sel, last_row_shadow_afifo_in_sel, wreg_in_sel
  );

  modport slave (
    output start, w_load_ack, act_valid, pe_ready,
    input  done, busy, w_load_req, act_rd_en,
           compressed_act_in_sel, last_row_shadow_afifo_in_sel, wreg_in_sel
  );
endinterface

// File: rtl/pe_array_in_sel_ctrl.sv
// Sequencer for the PE-array data-in muxes: per pass, one weight load plus one activation
// stream per kernel row. Optional PE_IN_CTRL_FORCE_DUMMY_EN adds a dbg_force_dummy override.
module pe_array_in_sel_ctrl #(
  parameter int LEN_W  = 16,
  parameter int PASS_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef PE_IN_CTRL_FORCE_DUMMY_EN
  input  logic                  dbg_force_dummy,
`endif
  pe_array_in_sel_ctrl_if.master bus,
  input  logic [1:0]            cfg_kernel_h,
  input  logic [LEN_W-1:0]      cfg_act_len,
  input  logic [PASS_W-1:0]     cfg_num_passes,
  output logic [1:0]            cur_krow,
  output logic [PASS_W-1:0]     cur_pass
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD_W = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
  localparam logic [PASS_W-1:0] PASS_ONE = PASS_W'(1);

  state_t              state_r, state_s;
  logic [1:0]          krow_r, krow_s, kh_m1_r;
  logic [PASS_W-1:0]   pass_r, pass_s, np_r;
  logic [LEN_W-1:0]    beat_r, beat_s, len_r;
  logic                latch_s, row_end_s, rd_en_s, force_s, active_s;
  logic                req_r, sel_en_r, busy_r, done_r;
  logic [1:0]          sel_r;

`ifdef PE_IN_CTRL_FORCE_DUMMY_EN
  assign force_s = dbg_force_dummy;
`else
  assign force_s = 1'b0;
`endif

  assign active_s = (state_s == S_LOAD_W) || (state_s == S_STREAM);

  // The beat transfer is combinational so a pop costs no extra cycle of latency.
  assign bus.act_rd_en                    = rd_en_s;
  assign bus.compressed_act_in_sel        = force_s ? 2'd0 : sel_r;
  assign bus.wreg_in_sel                  = sel_en_r & ~force_s;
  assign bus.last_row_shadow_afifo_in_sel = sel_en_r & ~force_s;
  assign bus.w_load_req                   = req_r;
  assign bus.busy                         = busy_r;
  assign bus.done                         = done_r;
  assign cur_krow                         = krow_r;
  assign cur_pass                         = pass_r;

  // Next-state, counter and end-of-kernel-row decisions.
  always_comb begin
    state_s   = state_r;
    krow_s    = krow_r;
    pass_s    = pass_r;
    beat_s    = beat_r;
    latch_s   = 1'b0;
    row_end_s = 1'b0;
    rd_en_s   = (state_r == S_STREAM) && bus.act_valid && bus.pe_ready && !force_s;
    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          latch_s = 1'b1;
          krow_s  = 2'd0;
          pass_s  = '0;
          beat_s  = '0;
          state_s = (cfg_num_passes == '0) ? S_DONE : S_LOAD_W;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOAD_W: begin
        if (bus.w_load_ack) begin
          beat_s = '0;
          // A zero-length stream skips STREAM entirely.
          if (len_r == '0) begin
            row_end_s = 1'b1;
          end else begin
            state_s = S_STREAM;
          end
        end else begin
          state_s = S_LOAD_W;
        end
      end
      S_STREAM: begin
        if (rd_en_s) begin
          if (beat_r == len_r - LEN_ONE) begin
            row_end_s = 1'b1;
          end else begin
            beat_s = beat_r + LEN_ONE;
          end
        end else begin
          beat_s = beat_r;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
    if (row_end_s) begin
      if (krow_r < kh_m1_r) begin
        krow_s  = krow_r + 2'd1;
        state_s = S_LOAD_W;
      end else if (pass_r < np_r - PASS_ONE) begin
        pass_s  = pass_r + PASS_ONE;
        krow_s  = 2'd0;
        state_s = S_LOAD_W;
      end else begin
        state_s = S_DONE;
      end
    end else begin
      krow_s = krow_s;
    end
  end

  // State, counters, latched config and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= S_IDLE;
      krow_r   <= 2'd0;
      pass_r   <= '0;
      beat_r   <= '0;
      kh_m1_r  <= 2'd0;
      len_r    <= '0;
      np_r     <= '0;
      req_r    <= 1'b0;
      sel_en_r <= 1'b0;
      sel_r    <= 2'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      krow_r  <= krow_s;
      pass_r  <= pass_s;
      beat_r  <= beat_s;
      if (latch_s) begin
        kh_m1_r <= (cfg_kernel_h == 2'd0) ? 2'd0 : (cfg_kernel_h - 2'd1);
        len_r   <= cfg_act_len;
        np_r    <= cfg_num_passes;
      end
      req_r    <= (state_s == S_LOAD_W);
      sel_en_r <= active_s;
      sel_r    <= active_s ? (krow_s + 2'd1) : 2'd0;
      busy_r   <= (state_s != S_IDLE);
      done_r   <= (state_s == S_DONE);
    end
  end

endmodule
